// File: rtl/key_sched_rev_pkg.sv
// Shared CSA key-schedule definitions: key width, round-index width, FSM states
// and the key permutation source-index table behind both perm directions.
package csa_pkg;

    localparam int CSA_KEY_W = 64;
    localparam int RIDX_W    = 3;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        EMIT
    } ks_state_t;

    // Output bit p of key_perm is taken from input bit PERM_SRC[p].
    localparam logic [5:0] PERM_SRC [CSA_KEY_W] = '{
        6'd45, 6'd50, 6'd55, 6'd60, 6'd1,  6'd6,  6'd11, 6'd16,
        6'd21, 6'd26, 6'd31, 6'd36, 6'd41, 6'd46, 6'd51, 6'd56,
        6'd61, 6'd2,  6'd7,  6'd12, 6'd17, 6'd22, 6'd40, 6'd32,
        6'd37, 6'd42, 6'd47, 6'd52, 6'd57, 6'd62, 6'd3,  6'd8,
        6'd13, 6'd18, 6'd23, 6'd28, 6'd33, 6'd38, 6'd43, 6'd48,
        6'd53, 6'd58, 6'd63, 6'd4,  6'd9,  6'd14, 6'd19, 6'd24,
        6'd29, 6'd34, 6'd39, 6'd44, 6'd49, 6'd54, 6'd59, 6'd0,
        6'd5,  6'd10, 6'd15, 6'd20, 6'd25, 6'd30, 6'd35, 6'd27
    };

    function automatic logic [CSA_KEY_W-1:0] key_perm(input logic [CSA_KEY_W-1:0] x);
        logic [CSA_KEY_W-1:0] y;
        y = '0;
        for (int p = 0; p < CSA_KEY_W; p++) begin
            y[p] = x[PERM_SRC[p]];
        end
        return y;
    endfunction

endpackage

// File: rtl/key_sched_rev_if.sv
// Key-in / round-key-out handshake bundle for key_sched_rev.
interface key_sched_rev_if;
    import csa_pkg::*;

    logic                 i_key_valid;
    logic                 i_key_ready;
    logic [CSA_KEY_W-1:0] i_key;
    logic                 o_rk_valid;
    logic                 o_rk_ready;
    logic [CSA_KEY_W-1:0] o_rk;
    logic [RIDX_W-1:0]    o_rk_idx;
    logic                 o_rk_last;

    modport slave (
        input  i_key_valid, i_key, o_rk_ready,
        output i_key_ready, o_rk_valid, o_rk, o_rk_idx, o_rk_last
    );

    modport master (
        output i_key_valid, i_key, o_rk_ready,
        input  i_key_ready, o_rk_valid, o_rk, o_rk_idx, o_rk_last
    );

endinterface

// File: rtl/key_sched_rev_perm_inv.sv
// Inverse of key_perm, scattering each input bit back to the position
// key_perm gathered it from.
module key_perm_inv
    import csa_pkg::*;
(
    input  logic [CSA_KEY_W-1:0] key_in,
    output logic [CSA_KEY_W-1:0] key_out
);

    always_comb begin
        key_out = '0;
        for (int p = 0; p < CSA_KEY_W; p++) begin
            key_out[PERM_SRC[p]] = key_in[p];
        end
    end

endmodule

// File: rtl/key_sched_rev.sv
// Reverse-order round-key streamer: expands the key forward ROUNDS steps,
// then emits schedule words walking back with the inverse permutation.
module key_sched_rev
    import csa_pkg::*;
#(
    parameter int ROUNDS = 7
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_abort,
    key_sched_rev_if.slave  bus,
    output logic            o_busy
);

    localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(ROUNDS - 1);

    ks_state_t            state;
    logic [CSA_KEY_W-1:0] key_reg;
    logic [CSA_KEY_W-1:0] key_prev;
    logic [RIDX_W-1:0]    cnt;
    logic [RIDX_W-1:0]    idx;
    logic                 rk_valid;

    key_perm_inv u_perm_inv (
        .key_in  (key_reg),
        .key_out (key_prev)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            key_reg <= '0;
            cnt     <= '0;
            idx     <= '0;
        end else if (i_abort) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_key_valid) begin
                        key_reg <= bus.i_key;
                        cnt     <= '0;
                        state   <= EXPAND;
                    end
                end
                EXPAND: begin
                    key_reg <= key_perm(key_reg);
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        idx   <= '0;
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.o_rk_ready) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= IDLE;
                        end else begin
                            key_reg <= key_prev;
                            idx     <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Abort masks both handshakes in its own cycle; word fields read zero when not valid.
    assign rk_valid        = (state == EMIT) && !i_abort;
    assign bus.o_rk_valid  = rk_valid;
    assign bus.o_rk        = rk_valid ? (key_reg ^ {8{5'b0, idx}}) : '0;
    assign bus.o_rk_idx    = rk_valid ? idx : '0;
    assign bus.o_rk_last   = rk_valid && (idx == LAST_IDX);
    assign bus.i_key_ready = (state == IDLE) && !rst && !i_abort;
    assign o_busy          = (state != IDLE);

endmodule
